// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    FETCH    = 2'd1,
    ERR      = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam int unsigned TMO_CNT_W = 8;

  // Sequential fetch address, wraps naturally at 2^32.
  function automatic logic [31:0] pc_seq(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending branch/jump redirect holder: set (newest wins), clear on PC load.
module pc_redirect_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_i,
  input  logic        clr_i,
  input  logic [31:0] target_i,
  output logic        pend_valid_o,
  output logic [31:0] pend_target_o
);

  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (set_i) begin
      pend_valid_d  = 1'b1;
      pend_target_d = target_i;
    end else if (clr_i) begin
      pend_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pend_valid_o  = pend_valid_q;
  assign pend_target_o = pend_target_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer with imem handshake, redirect buffering and timeout error.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        StallD,
  input  logic        BranchTakenD,
  input  logic [31:0] BranchTarget,
  input  logic        JumpD,
  input  logic [31:0] JumpTarget,
  input  logic        ImemReady,
  output logic        ImemReq,
  output logic [31:0] PC_next,
  output logic        PC_en,
  output logic        StallF,
  output logic        FlushD,
  output logic        ImemErr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] RedirectCount
`endif
);

  fetch_state_e         state_q, state_d;
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 tmo_trip;

  logic                 advance;
  logic                 redirect_acc;
  logic [31:0]          redirect_tgt;
  logic                 pend_valid;
  logic [31:0]          pend_target;

  assign cnt_inc  = cnt_q + TMO_CNT_W'(1);
  assign tmo_trip = ({{(32 - TMO_CNT_W){1'b0}}, cnt_inc} >= IMEM_TIMEOUT);

  // Outputs and handshake decode.
  always_comb begin
    ImemReq      = 1'b0;
    StallF       = 1'b0;
    ImemErr      = 1'b0;
    advance      = 1'b0;
    redirect_acc = 1'b0;
    unique case (state_q)
      RST_HOLD: begin
        StallF       = 1'b0;
        redirect_acc = (BranchTakenD | JumpD) & ~StallD;
      end
      FETCH: begin
        ImemReq      = 1'b1;
        advance      = ImemReady & ~StallD;
        StallF       = ~advance;
        redirect_acc = (BranchTakenD | JumpD) & ~StallD;
      end
      ERR: begin
        StallF  = 1'b1;
        ImemErr = 1'b1;
      end
      default: begin
        StallF = 1'b1;
      end
    endcase

    redirect_tgt = JumpD ? JumpTarget : BranchTarget;

    if (redirect_acc) begin
      PC_next = redirect_tgt;
    end else if (pend_valid) begin
      PC_next = pend_target;
    end else begin
      PC_next = pc_seq(PC);
    end

    PC_en  = advance;
    FlushD = advance & (redirect_acc | pend_valid);
  end

  // State and timeout counter next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RST_HOLD: begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: begin
        if (advance || ImemReady) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (tmo_trip) begin
            state_d = ERR;
          end
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = ERR;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A redirect that cannot load this cycle is parked until the next advance.
  pc_redirect_buf u_redirect_buf (
    .clk_i         (CLK),
    .rst_i         (reset),
    .set_i         (redirect_acc & ~PC_en),
    .clr_i         (PC_en),
    .target_i      (redirect_tgt),
    .pend_valid_o  (pend_valid),
    .pend_target_o (pend_target)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if ((state_q == FETCH) && !PC_en) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (FlushD) begin
      redir_cnt_d = redir_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      redir_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign StallCount    = stall_cnt_q;
  assign RedirectCount = redir_cnt_q;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage controller for the pipelined MIPS core. Sequences the program-counter register by producing its next value and load enable, handshakes with instruction memory, and buffers branch/jump redirects that arrive while fetch is blocked. Also produces the fetch stall and the decode flush. Sits between the hazard unit, the decode-stage branch logic, instruction memory and the PC register.

## Interface
- `IMEM_TIMEOUT`, default 16: number of consecutive not-ready cycles, counted while a fetch is outstanding, that trips the memory error (range 2..255).
- `CLK` input 1: clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset. This is already decided.
- `PC` input 32: current PC register value.
- `StallD` input 1: stall from the hazard unit. Fetch must not advance.
- `BranchTakenD` input 1: a branch resolved as taken in decode.
- `BranchTarget` input 32: branch target address.
- `JumpD` input 1: a jump is in decode.
- `JumpTarget` input 32: jump target address.
- `ImemReady` input 1: instruction memory delivers the fetch at `PC` this cycle.
- `ImemReq` output 1: fetch request to instruction memory.
- `PC_next` output 32: value to load into the PC register.
- `PC_en` output 1: PC register load enable.
- `StallF` output 1: fetch stage stalled. Holds the IF/ID register.
- `FlushD` output 1: clear the IF/ID register.
- `ImemErr` output 1: sticky memory-timeout error.

## Operation
- States:
  - `RST_HOLD`: the first cycle after `reset` deasserts.
  - `FETCH`: request issued and awaiting or accepting.
  - `ERR`: memory timeout.
- State transitions:
  - `RST_HOLD` goes to `FETCH` unconditionally.
  - `FETCH` goes to `ERR` when the timeout counter reaches `IMEM_TIMEOUT`.
  - `ERR` is left only by `reset`.
- `ImemReq` is 1 only in `FETCH`.
- Advance condition, all of the following:
  - state is `FETCH`;
  - `ImemReady`;
  - `~StallD`.
- When the advance condition holds, `PC_en` is 1. Otherwise `PC_en` is 0.
- `StallF` is 1 in `FETCH` whenever the advance condition does not hold. `StallF` is 0 in `RST_HOLD`. `StallF` is 1 in `ERR`.
- Redirect acceptance:
  - A redirect is accepted when `(BranchTakenD | JumpD) & ~StallD`.
  - If both requests are asserted, `JumpD` wins.
- `PC_next` selection, in priority order:
  1. The redirect accepted this cycle.
  2. The pending redirect.
  3. `PC + 4`, modulo 2^32, so `0xFFFFFFFC` wraps to `0x00000000`.
- Pending redirect buffer:
  - When a redirect is accepted and `PC_en` is 0, the target is stored and `pend_valid` is set.
  - `pend_valid` is cleared on the first `PC_en`.
  - A newer accepted redirect overwrites the pending one.
- `FlushD = PC_en & (redirect accepted this cycle | pend_valid)`. This squashes the wrong-path instruction.
- Timeout counter (8 bits):
  - Cleared on `PC_en`, in `RST_HOLD`, and whenever `ImemReady` is 1.
  - Increments in `FETCH` while `ImemReady` is 0.
  - `StallD`-only cycles do not count.
- In `ERR`: `ImemErr` is 1, `PC_en` is 0, `FlushD` is 0, and redirects are ignored.

## Timing
- All outputs are combinational from state, the pending buffer and the inputs, with zero latency.
- The PC register updates on the edge after `PC_en` is high.
- A redirect that lands in the same cycle as the advance condition takes effect at the next edge. A buffered redirect takes effect at the first subsequent advance.
- Reset values, while `reset` is high:
  - state is `RST_HOLD`;
  - `pend_valid` is 0;
  - the counter is 0;
  - `ImemReq` is 0, `PC_en` is 0, `FlushD` is 0, `ImemErr` is 0;
  - `PC_next` is `PC + 4`.
- Reset asserted mid-wait or mid-pending discards the buffered redirect immediately.
- `ImemReady` while `StallD` is 1: no advance, and the counter clears.

## Configuration
- `FETCH_PERF_EN`: when defined, adds two outputs.
  - `StallCount` output 32: cycles spent in `FETCH` with `PC_en` = 0.
  - `RedirectCount` output 32: cycles with `FlushD` = 1.
  - Both counters clear on reset and wrap at 2^32.
- When `FETCH_PERF_EN` is undefined, neither port nor any counter logic exists.

## Structure
- Package `pc_ctrl_pkg` holds:
  - the state enum (`RST_HOLD`, `FETCH`, `ERR`);
  - the `PC_INCR = 4` constant;
  - the 8-bit timeout counter width.
- One sub-module, `pc_redirect_buf`, holds the pending target register and `pend_valid`, with set, clear and overwrite behaviour.

## Test plan
- Reset release with `ImemReady`=1 and `PC`=0: one cycle with `PC_en`=0. The next cycle `PC_en`=1 and `PC_next`=`0x4`. At `PC`=`0xFFFFFFFC`, `PC_next`=`0x0`.
- `StallD`=1 for 3 cycles with `ImemReady`=1: `PC_en`=0 and `StallF`=1 for 3 cycles, and `ImemErr` stays 0.
- `BranchTakenD`=1 with `BranchTarget`=`0x40` and `ImemReady`=1: `PC_next`=`0x40`, `PC_en`=1, `FlushD`=1 in the same cycle.
- `JumpD`=1 with `JumpTarget`=`0x100` while `ImemReady`=0 for 2 cycles: buffered. On the first ready cycle `PC_next`=`0x100` and `FlushD`=1. On the following advance `PC_next`=`PC+4` and `FlushD`=0.
- `ImemReady` held 0 for 16 cycles: `ImemErr` rises. `PC_en` stays 0 through further redirects until `reset`.
